// File: rtl/control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back,
// with single-step mode and a terminal display state.
module control_fsm (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        step_en,
  input  logic        step,
  output logic [3:0]  state,
  output logic        readMem,
  output logic        writeMem,
  output logic        irWrite,
  output logic        mdrWrite,
  output logic        regWrite,
  output logic        pcWrite,
  output logic        memToReg,
  output logic        iorD,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic [1:0]  pcSrc,
  output logic        erro,
  output logic [15:0] instr_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    FETCH     = 4'b0000,
    DECODE    = 4'b0001,
    EXEC_ALU  = 4'b0010,
    WB_ALU    = 4'b0011,
    ADDR      = 4'b0100,
    MEM_READ  = 4'b0101,
    WB_LOAD   = 4'b0110,
    BRANCH    = 4'b0111,
    JUMP      = 4'b1000,
    IDLE      = 4'b1001,
    DISPLAY   = 4'b1010,
    MEM_WRITE = 4'b1011
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic             erro_q;
  logic [CNT_W-1:0] count_q;
  logic             step_s1, step_s2, step_d;
  logic             step_rise;
  logic             done;
  logic             erro_set;

  // step button: 2-flop synchronizer followed by a rising-edge detector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_d  <= step_s2;
    end
  end

  assign step_rise = step_s2 & ~step_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      erro_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (erro_set) erro_q <= 1'b1;
      if (done && (count_q != {CNT_W{1'b1}})) count_q <= count_q + CNT_W'(1);
    end
  end

  // next-state, instruction completion and error detection
  always_comb begin
    state_d  = state_q;
    phase_d  = 1'b0;
    done     = 1'b0;
    erro_set = 1'b0;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        if (!opcode[3])             state_d = EXEC_ALU;
        else if (opcode == 4'h8 || opcode == 4'h9) state_d = ADDR;
        else if (opcode == 4'hA)    state_d = JUMP;
        else if (opcode == 4'hB)    state_d = BRANCH;
        else begin
          state_d  = DISPLAY;
          erro_set = (opcode != 4'hC);
        end
      end
      EXEC_ALU: state_d = WB_ALU;
      ADDR:     state_d = (opcode == 4'h9) ? MEM_WRITE : MEM_READ;
      MEM_READ: state_d = WB_LOAD;
      MEM_WRITE: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = step_en ? IDLE : FETCH;
        end
      end
      WB_ALU, WB_LOAD, BRANCH, JUMP: begin
        done    = 1'b1;
        state_d = step_en ? IDLE : FETCH;
      end
      IDLE:     if (!step_en || step_rise) state_d = FETCH;
      DISPLAY:  state_d = DISPLAY;
      default: begin
        state_d  = DISPLAY;
        erro_set = 1'b1;
      end
    endcase
  end

  // Moore decode of the registered state; pcWrite in BRANCH follows zero
  always_comb begin
    readMem  = 1'b0;
    writeMem = 1'b0;
    irWrite  = 1'b0;
    mdrWrite = 1'b0;
    regWrite = 1'b0;
    pcWrite  = 1'b0;
    memToReg = 1'b0;
    iorD     = 1'b0;
    aluSrcB  = 2'b00;
    aluOp    = 2'b00;
    pcSrc    = 2'b00;
    case (state_q)
      FETCH: begin
        readMem = 1'b1;
        irWrite = 1'b1;
        aluSrcB = 2'b01;
        pcWrite = 1'b1;
      end
      EXEC_ALU: aluOp = 2'b10;
      WB_ALU:   regWrite = 1'b1;
      ADDR:     aluSrcB = 2'b10;
      MEM_READ: begin
        readMem  = 1'b1;
        iorD     = 1'b1;
        mdrWrite = 1'b1;
      end
      WB_LOAD: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      MEM_WRITE: begin
        writeMem = ~phase_q;
        iorD     = ~phase_q;
      end
      BRANCH: begin
        aluOp   = 2'b01;
        pcSrc   = 2'b01;
        pcWrite = zero;
      end
      JUMP: begin
        pcSrc   = 2'b10;
        pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign erro        = erro_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class, step mode,
// halt/illegal handling and reset during a memory write.
module tb_control_fsm;

  logic        clock;
  logic        reset_n;
  logic [3:0]  opcode;
  logic        zero;
  logic        step_en;
  logic        step;
  logic [3:0]  state;
  logic        readMem, writeMem, irWrite, mdrWrite, regWrite, pcWrite, memToReg, iorD;
  logic [1:0]  aluSrcB, aluOp, pcSrc;
  logic        erro;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  control_fsm dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .step_en(step_en), .step(step), .state(state),
    .readMem(readMem), .writeMem(writeMem), .irWrite(irWrite), .mdrWrite(mdrWrite),
    .regWrite(regWrite), .pcWrite(pcWrite), .memToReg(memToReg), .iorD(iorD),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc), .erro(erro),
    .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {rd, wr, ir, mdr, regw, pcw, m2r, iord, srcB, aluOp, pcSrc}
  logic [13:0] sig;
  assign sig = {readMem, writeMem, irWrite, mdrWrite, regWrite, pcWrite, memToReg, iorD,
                aluSrcB, aluOp, pcSrc};

  localparam logic [13:0] S_NONE  = 14'b00000000_00_00_00;
  localparam logic [13:0] S_FETCH = 14'b10100100_01_00_00;
  localparam logic [13:0] S_EXEC  = 14'b00000000_00_10_00;
  localparam logic [13:0] S_WBALU = 14'b00001000_00_00_00;
  localparam logic [13:0] S_ADDR  = 14'b00000000_10_00_00;
  localparam logic [13:0] S_MW0   = 14'b01000001_00_00_00;
  localparam logic [13:0] S_MR    = 14'b10010001_00_00_00;
  localparam logic [13:0] S_WBLD  = 14'b00001010_00_00_00;
  localparam logic [13:0] S_BR1   = 14'b00000100_00_01_01;
  localparam logic [13:0] S_BR0   = 14'b00000000_00_01_01;
  localparam logic [13:0] S_JUMP  = 14'b00000100_00_00_10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] exp_state, input logic [13:0] exp_sig);
    tick();
    chk({tag, "_state"}, 32'(state), 32'(exp_state));
    chk({tag, "_sig"}, 32'(sig), 32'(exp_sig));
  endtask

  initial begin
    int n;
    reset_n = 1'b0; opcode = 4'h0; zero = 1'b0; step_en = 1'b0; step = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'h9);
    chk("rst_sig", 32'(sig), 32'(S_NONE));
    chk("rst_cnt", 32'(instr_count), 32'h0);
    chk("rst_erro", 32'(erro), 32'h0);
    reset_n = 1'b1;

    // ALU op 0x2
    opcode = 4'h2;
    step_chk("alu_f", 4'h0, S_FETCH);
    step_chk("alu_d", 4'h1, S_NONE);
    step_chk("alu_x", 4'h2, S_EXEC);
    step_chk("alu_wb", 4'h3, S_WBALU);
    chk("alu_cnt_pre", 32'(instr_count), 32'h0);
    step_chk("alu_next", 4'h0, S_FETCH);
    chk("alu_cnt", 32'(instr_count), 32'h1);

    // SW
    opcode = 4'h9;
    step_chk("sw_d", 4'h1, S_NONE);
    step_chk("sw_a", 4'h4, S_ADDR);
    step_chk("sw_m0", 4'hB, S_MW0);
    step_chk("sw_m1", 4'hB, S_NONE);
    step_chk("sw_next", 4'h0, S_FETCH);
    chk("sw_cnt", 32'(instr_count), 32'h2);

    // LW
    opcode = 4'h8;
    step_chk("lw_d", 4'h1, S_NONE);
    step_chk("lw_a", 4'h4, S_ADDR);
    step_chk("lw_mr", 4'h5, S_MR);
    step_chk("lw_wb", 4'h6, S_WBLD);
    step_chk("lw_next", 4'h0, S_FETCH);
    chk("lw_cnt", 32'(instr_count), 32'h3);

    // BEQ, both values of zero while in BRANCH
    opcode = 4'hB; zero = 1'b1;
    step_chk("beq_d", 4'h1, S_NONE);
    step_chk("beq_br1", 4'h7, S_BR1);
    zero = 1'b0;
    #1;
    chk("beq_br0_sig", 32'(sig), 32'(S_BR0));
    step_chk("beq_next", 4'h0, S_FETCH);
    chk("beq_cnt", 32'(instr_count), 32'h4);

    // J
    opcode = 4'hA;
    step_chk("j_d", 4'h1, S_NONE);
    step_chk("j_j", 4'h8, S_JUMP);
    step_chk("j_next", 4'h0, S_FETCH);
    chk("j_cnt", 32'(instr_count), 32'h5);

    // single-step: finish an ALU op into IDLE, hold without a step edge
    step_en = 1'b1; opcode = 4'h0;
    step_chk("ss_d", 4'h1, S_NONE);
    step_chk("ss_x", 4'h2, S_EXEC);
    step_chk("ss_wb", 4'h3, S_WBALU);
    step_chk("ss_idle", 4'h9, S_NONE);
    chk("ss_cnt", 32'(instr_count), 32'h6);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("ss_hold", 32'(state), 32'h9);
    end

    // one step pulse releases exactly one J instruction
    opcode = 4'hA;
    step = 1'b1;
    n = 0;
    while (state != 4'h0 && n < 10) begin
      tick();
      n++;
    end
    chk("ss_release_fetch", 32'(state), 32'h0);
    chk("ss_release_lat", 32'(n), 32'd3);
    step_chk("ss_j_d", 4'h1, S_NONE);
    step_chk("ss_j_j", 4'h8, S_JUMP);
    step_chk("ss_j_idle", 4'h9, S_NONE);
    chk("ss_j_cnt", 32'(instr_count), 32'h7);
    step = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ss_j_hold", 32'(state), 32'h9);

    // reset during MEM_WRITE phase 0
    step_en = 1'b0; opcode = 4'h9;
    step_chk("rw_f", 4'h0, S_FETCH);
    step_chk("rw_d", 4'h1, S_NONE);
    step_chk("rw_a", 4'h4, S_ADDR);
    step_chk("rw_m0", 4'hB, S_MW0);
    reset_n = 1'b0;
    #1;
    chk("rw_state", 32'(state), 32'h9);
    chk("rw_wr", 32'(writeMem), 32'h0);
    chk("rw_cnt", 32'(instr_count), 32'h0);
    tick();
    reset_n = 1'b1;

    // HALT: terminal display state
    opcode = 4'hC;
    step_chk("h_f", 4'h0, S_FETCH);
    step_chk("h_d", 4'h1, S_NONE);
    for (int i = 0; i < 100; i++) begin
      step_chk("h_hold", 4'hA, S_NONE);
    end
    chk("h_cnt", 32'(instr_count), 32'h0);
    chk("h_erro", 32'(erro), 32'h0);

    // illegal opcode
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    opcode = 4'hE;
    step_chk("il_f", 4'h0, S_FETCH);
    step_chk("il_d", 4'h1, S_NONE);
    step_chk("il_disp", 4'hA, S_NONE);
    chk("il_erro", 32'(erro), 32'h1);
    step_chk("il_hold", 4'hA, S_NONE);
    chk("il_erro_sticky", 32'(erro), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the 16-bit processor. It sequences every instruction through fetch, decode, execute, memory and write-back. It drives the 4-bit `state` bus and the `readMem`/`writeMem` strobes consumed directly by the 50-word memory block, plus the datapath enables for the PC, IR, MDR, register file and ALU. It also supports single-step mode and halts into the display state, where memory contents are shown on the displays.

## Interface
- No parameters; state encoding is fixed (below).
- `clock` in 1: system clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: IR[15:12], valid from DECODE onward.
- `zero` in 1: ALU zero flag, valid in BRANCH.
- `step_en` in 1: 1 = single-step mode.
- `step` in 1: asynchronous push-button; a rising edge releases one instruction.
- `state` out 4: current state code, sent to memory and displays.
- `readMem` out 1: memory read strobe. Memory captures on its rising edge.
- `writeMem` out 1: memory write strobe. Memory commits on its falling edge while `state`=1011.
- `irWrite`, `mdrWrite`, `regWrite`, `pcWrite`, `memToReg`, `iorD` out 1 each: datapath enables and selects.
- `aluSrcB` out 2: 00 = reg B, 01 = constant 1, 10 = sign-extended imm.
- `aluOp` out 2: 00 = add, 01 = subtract, 10 = function from opcode.
- `pcSrc` out 2: 00 = ALU result, 01 = branch target, 10 = jump target.
- `erro` out 1: sticky illegal-opcode flag.
- `instr_count` out 16: number of completed instructions, saturates at FFFF.

## Operation
- State codes:
  - 0000 FETCH, 0001 DECODE, 0010 EXEC_ALU, 0011 WB_ALU
  - 0100 ADDR, 0101 MEM_READ, 0110 WB_LOAD, 0111 BRANCH
  - 1000 JUMP, 1001 IDLE, 1010 DISPLAY, 1011 MEM_WRITE
- Codes 1100–1111 are unused. If reached, the FSM goes to DISPLAY with `erro`=1.
- Opcodes:
  - 0x0–0x7: ALU ops.
  - 0x8: LW → ADDR → MEM_READ → WB_LOAD.
  - 0x9: SW → ADDR → MEM_WRITE.
  - 0xA: J → JUMP.
  - 0xB: BEQ → BRANCH.
  - 0xC: HALT → DISPLAY.
  - 0xD–0xF: illegal → DISPLAY, `erro`=1.
- FETCH: `readMem`=1, `iorD`=0, `irWrite`=1, `aluSrcB`=01, `aluOp`=00, `pcWrite`=1, `pcSrc`=00.
- DECODE: all strobes 0. Dispatch on `opcode`.
- EXEC_ALU: `aluSrcB`=00, `aluOp`=10.
- WB_ALU: `regWrite`=1, `memToReg`=0.
- ADDR: `aluSrcB`=10, `aluOp`=00.
- MEM_READ: `readMem`=1, `iorD`=1, `mdrWrite`=1.
- WB_LOAD: `regWrite`=1, `memToReg`=1.
- MEM_WRITE lasts exactly 2 cycles, tracked by an internal phase bit:
  - Phase 0: `writeMem`=1, `iorD`=1.
  - Phase 1: `writeMem`=0, `state` held at 1011, so the falling edge lands while `state`=1011.
- BRANCH: `aluOp`=01, `pcSrc`=01, `pcWrite`=`zero`.
- JUMP: `pcSrc`=10, `pcWrite`=1.
- Last state of each instruction (WB_ALU, WB_LOAD, MEM_WRITE phase 1, BRANCH, JUMP):
  - Next state is FETCH if `step_en`=0, else IDLE.
  - `instr_count` increments (saturating).
- IDLE: all strobes 0. Goes to FETCH on a synchronized rising edge of `step`, or immediately if `step_en`=0.
- `step` path: 2-flop synchronizer, then an edge detector. An edge seen outside IDLE is discarded, not queued.
- DISPLAY is terminal until reset. All strobes are 0 there; the memory shows `memory[CHAVE]`.
- Any output not listed for a state is 0.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - `state`=1001 (IDLE), phase=0, `erro`=0, `instr_count`=0.
  - All strobes 0.
- First FETCH is the cycle after reset release if `step_en`=0.
- Outputs are Moore outputs decoded from registered state. `pcWrite` in BRANCH is the only Mealy term (`zero`).
- Latency in cycles:
  - ALU: 4
  - LW: 5
  - SW: 5
  - BEQ: 3
  - J: 3
  - Each instruction adds 1 cycle in step mode (the IDLE cycle).
- `readMem` is high for exactly one cycle per FETCH or MEM_READ, so it rises once per access. Back-to-back reads are always separated by a low cycle, because DECODE follows FETCH.
- Reset asserted mid MEM_WRITE phase 0 drops `writeMem` while `state` becomes 1001, so no write commits.

## Test plan
- Reset, `step_en`=0, ALU opcode 0x2 fed at DECODE → `state` sequence 1001, 0000, 0001, 0010, 0011, 0000. `instr_count`=1 after WB_ALU.
- Opcode 0x9 (SW) → 0000, 0001, 0100, 1011, 1011. `writeMem` is 1 then 0, and its falling edge occurs with `state`=1011.
- Opcode 0xB with `zero`=1 → `pcWrite`=1 and `pcSrc`=01 in BRANCH. With `zero`=0 → `pcWrite`=0. Both take 3 cycles.
- Opcode 0xC → `state`=1010 held for 100 cycles, all strobes 0, `instr_count` unchanged. Opcode 0xE → `state`=1010 and `erro`=1.
- `step_en`=1, no `step` edge for 50 cycles → `state` stays 1001. One `step` pulse → exactly one instruction runs, then back to 1001.
- `reset_n` pulled low during MEM_WRITE phase 0 → `state`=1001 immediately, `writeMem`=0, `instr_count`=0.
